rsa256_stream_frontend: RTL and testbench

Byte-stream front end for the RSA256 decryption core. Collects modulus N, exponent D and one 256-bit ciphertext block from an 8-bit valid/ready receive stream, pulses the core's start, waits for its finished pulse, and streams the 31 low-order plaintext bytes out on an 8-bit valid/ready transmit stream. After each block it returns to collecting the next ciphertext block and keeps N and D.

---
 rtl/rsa256_stream_frontend.sv | 148 ++++++++++++++
 tb/tb_rsa256_stream_frontend.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa256_stream_frontend.sv
// rsa256_stream_frontend
//
// Byte-stream front end for the RSA256 decryption core. It loads modulus N,
// exponent D and one ciphertext block A from an 8-bit valid/ready receive
// stream (MSB-first within each field). It then pulses the core's start,
// waits for the core's finished pulse, and streams the OUT_BYTES low-order
// plaintext bytes out on an 8-bit valid/ready transmit stream. After each
// block only a new A is collected; N and D stay loaded.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_rx_data/valid       receive byte stream; o_rx_ready accepts it
//   o_tx_data/valid       transmit byte stream; i_tx_ready accepts it
//   o_core_start          one-cycle start pulse to the core
//   o_core_a/d/n          ciphertext, exponent and modulus held for the core
//   i_core_a_pow_d        core result
//   i_core_finished       core one-cycle done pulse
//
// state  | meaning
// -------+-----------------------------------------------------------
// GET_N  | shifting in KEY_BYTES modulus bytes
// GET_D  | shifting in KEY_BYTES exponent bytes
// GET_A  | shifting in KEY_BYTES ciphertext bytes
// START  | o_core_start high for this single cycle
// WAIT   | core busy; leave when i_core_finished is sampled high
// SEND   | shifting OUT_BYTES plaintext bytes out, top byte first

module rsa256_stream_frontend #(
    parameter int KEY_BYTES = 32,
    parameter int OUT_BYTES = 31
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_a_pow_d,
    input  logic         i_core_finished
);

    localparam int CW = $clog2(KEY_BYTES);
    localparam int OW = 8 * OUT_BYTES;

    typedef enum logic [2:0] {
        GET_N,
        GET_D,
        GET_A,
        START,
        WAIT,
        SEND
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [255:0]    n_q;
    logic [255:0]    d_q;
    logic [255:0]    a_q;
    logic [OW-1:0]   out_q;

    logic            rx_ready;
    logic            rx_fire;
    logic            tx_fire;
    logic            last_rx;
    logic            last_tx;

    // The plaintext is below N and the protocol only carries OUT_BYTES
    // bytes, so the result bits above the output register are dropped.
    logic            unused_result_bits;
    assign unused_result_bits = ^i_core_a_pow_d[255:OW];

    assign rx_ready = (state_q == GET_N) || (state_q == GET_D) || (state_q == GET_A);
    assign rx_fire  = rx_ready && i_rx_valid;
    assign tx_fire  = (state_q == SEND) && i_tx_ready;
    assign last_rx  = (cnt_q == CW'(KEY_BYTES - 1));
    assign last_tx  = (cnt_q == CW'(OUT_BYTES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            GET_N:   if (rx_fire && last_rx) state_d = GET_D;
            GET_D:   if (rx_fire && last_rx) state_d = GET_A;
            GET_A:   if (rx_fire && last_rx) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (i_core_finished) state_d = SEND;
            SEND:    if (tx_fire && last_tx) state_d = GET_A;
            default: state_d = GET_N;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= GET_N;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter clears on every state entry, so the final byte of a field
    // both advances the state and wraps the count back to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (rx_fire || tx_fire) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            n_q <= '0;
            d_q <= '0;
            a_q <= '0;
        end else if (rx_fire) begin
            if (state_q == GET_N) n_q <= {n_q[247:0], i_rx_data};
            if (state_q == GET_D) d_q <= {d_q[247:0], i_rx_data};
            if (state_q == GET_A) a_q <= {a_q[247:0], i_rx_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q <= '0;
        end else if ((state_q == WAIT) && i_core_finished) begin
            out_q <= i_core_a_pow_d[OW-1:0];
        end else if (tx_fire) begin
            out_q <= {out_q[OW-9:0], 8'h00};
        end
    end

    assign o_rx_ready   = rx_ready;
    assign o_tx_valid   = (state_q == SEND);
    assign o_tx_data    = out_q[OW-1 -: 8];
    assign o_core_start = (state_q == START);
    assign o_core_n     = n_q;
    assign o_core_d     = d_q;
    assign o_core_a     = a_q;

endmodule

// File: tb/tb_rsa256_stream_frontend.sv
module tb_rsa256_stream_frontend;

    localparam int KEY_BYTES = 32;
    localparam int OUT_BYTES = 31;

    logic         i_clk;
    logic         i_rst_n;
    logic [7:0]   i_rx_data;
    logic         i_rx_valid;
    logic         o_rx_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready;
    logic         o_core_start;
    logic [255:0] o_core_a;
    logic [255:0] o_core_d;
    logic [255:0] o_core_n;
    logic [255:0] i_core_a_pow_d;
    logic         i_core_finished;

    logic         core_fin;
    logic         spur_fin;
    logic [255:0] core_res;

    assign i_core_finished = core_fin | spur_fin;
    assign i_core_a_pow_d  = core_res;

    rsa256_stream_frontend #(.KEY_BYTES(KEY_BYTES), .OUT_BYTES(OUT_BYTES)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_rx_data       (i_rx_data),
        .i_rx_valid      (i_rx_valid),
        .o_rx_ready      (o_rx_ready),
        .o_tx_data       (o_tx_data),
        .o_tx_valid      (o_tx_valid),
        .i_tx_ready      (i_tx_ready),
        .o_core_start    (o_core_start),
        .o_core_a        (o_core_a),
        .o_core_d        (o_core_d),
        .o_core_n        (o_core_n),
        .i_core_a_pow_d  (i_core_a_pow_d),
        .i_core_finished (i_core_finished)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int           total = 0;
    int           bad = 0;
    logic [7:0]   exp_q[$];
    int           blocks_issued = 0;
    int           starts_seen = 0;
    int           tx_popped = 0;
    logic [255:0] mdl_n;
    logic [255:0] mdl_d;

    function automatic void check(input bit ok, input string name,
                                  input logic [255:0] act, input logic [255:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endfunction

    function automatic longint unsigned modexp(input longint unsigned b,
                                               input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r;
        longint unsigned x;
        longint unsigned k;
        r = 1 % m;
        x = b % m;
        k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % m;
            x = (x * x) % m;
            k = k >> 1;
        end
        return r;
    endfunction

    // Stub RSA core: samples the operands on start, computes a^d mod n after
    // a random latency, and puts garbage in the discarded top byte.
    initial begin
        longint unsigned r;
        core_fin = 1'b0;
        core_res = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_core_start) begin
                r = modexp(o_core_a[63:0], o_core_d[63:0], o_core_n[63:0]);
                repeat ($urandom_range(3, 20)) @(posedge i_clk);
                #1;
                core_res = {8'($urandom), 248'(r)};
                core_fin = 1'b1;
                @(posedge i_clk);
                #1;
                core_fin = 1'b0;
                core_res = {8{$urandom}};
            end
        end
    end

    always @(negedge i_clk) if (i_rst_n && o_core_start) starts_seen++;

    // Transmit sink: random ready, plus one 50-cycle stall in the first block.
    initial begin
        bit stalled;
        stalled = 1'b0;
        i_tx_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (!stalled && tx_popped == 10) begin
                stalled = 1'b1;
                i_tx_ready = 1'b0;
                repeat (50) @(posedge i_clk);
                #1;
            end
            i_tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard
    initial begin
        bit         armed;
        bit         prev_valid;
        bit         prev_ready;
        logic [7:0] prev_data;
        int         blk_cnt;
        logic [7:0] want;
        armed = 0;
        prev_valid = 0;
        prev_ready = 0;
        prev_data = 0;
        blk_cnt = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (core_fin) armed = 1;
                if (o_tx_valid) begin
                    check(armed, "tx_before_finished", o_tx_valid, 0);
                    check(o_rx_ready == 1'b0, "rx_ready_in_send", o_rx_ready, 0);
                    if (prev_valid && !prev_ready)
                        check(o_tx_data == prev_data, "tx_stable_stall", o_tx_data, prev_data);
                    if (i_tx_ready) begin
                        if (exp_q.size() == 0) begin
                            check(1'b0, "tx_unexpected", o_tx_data, 0);
                        end else begin
                            want = exp_q.pop_front();
                            check(o_tx_data == want, "tx_byte", o_tx_data, want);
                        end
                        tx_popped++;
                        blk_cnt++;
                        if (blk_cnt == OUT_BYTES) begin
                            blk_cnt = 0;
                            armed = 0;
                        end
                    end
                end
            end
            prev_valid = o_tx_valid;
            prev_ready = i_tx_ready;
            prev_data  = o_tx_data;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic rx_byte(input logic [7:0] b);
        int guard;
        bit hs;
        while ($urandom_range(0, 3) == 0) begin
            i_rx_valid = 1'b0;
            i_rx_data  = 8'($urandom);
            @(posedge i_clk);
            #1;
        end
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        guard = 0;
        hs = 0;
        while (!hs && guard < 3000) begin
            @(negedge i_clk);
            hs = o_rx_ready;
            @(posedge i_clk);
            #1;
            guard++;
        end
        if (!hs) check(hs, "rx_handshake_timeout", guard, 0);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic send_field(input logic [255:0] v);
        for (int i = KEY_BYTES - 1; i >= 0; i--) rx_byte(v[8*i +: 8]);
    endtask

    task automatic load_key(input logic [255:0] n, input logic [255:0] d);
        mdl_n = n;
        mdl_d = d;
        send_field(n);
        send_field(d);
    endtask

    task automatic load_block(input logic [255:0] a, input bit spur);
        logic [255:0] rr;
        rr = 256'(modexp(a[63:0], mdl_d[63:0], mdl_n[63:0]));
        for (int j = OUT_BYTES - 1; j >= 0; j--) exp_q.push_back(rr[8*j +: 8]);
        blocks_issued++;
        for (int i = KEY_BYTES - 1; i >= 0; i--) begin
            rx_byte(a[8*i +: 8]);
            if (spur && i == 16) begin
                spur_fin = 1'b1;
                @(posedge i_clk);
                #1;
                spur_fin = 1'b0;
                @(negedge i_clk);
                check(o_tx_valid == 1'b0, "spurious_tx_valid", o_tx_valid, 0);
                check(o_rx_ready == 1'b1, "spurious_rx_ready", o_rx_ready, 1);
                @(posedge i_clk);
                #1;
            end
        end
        @(negedge i_clk);
        check(o_core_start == 1'b1, "start_pulse", o_core_start, 1);
        check(o_core_a == a, "core_a", o_core_a, a);
        check(o_core_n == mdl_n, "core_n", o_core_n, mdl_n);
        check(o_core_d == mdl_d, "core_d", o_core_d, mdl_d);
        @(negedge i_clk);
        check(o_core_start == 1'b0, "start_one_cycle", o_core_start, 0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(exp_q.size() == 0 && o_rx_ready) && guard < 5000) begin
            @(negedge i_clk);
            guard++;
        end
        check(exp_q.size() == 0 && o_rx_ready, "idle_timeout", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check(o_rx_ready == 1'b1, {tag, "_rx_ready"}, o_rx_ready, 1);
        check(o_tx_valid == 1'b0, {tag, "_tx_valid"}, o_tx_valid, 0);
        check(o_tx_data == 8'h00, {tag, "_tx_data"}, o_tx_data, 0);
        check(o_core_start == 1'b0, {tag, "_start"}, o_core_start, 0);
        check(o_core_n == '0, {tag, "_core_n"}, o_core_n, 0);
        check(o_core_d == '0, {tag, "_core_d"}, o_core_d, 0);
        check(o_core_a == '0, {tag, "_core_a"}, o_core_a, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] n2;
        logic [255:0] d2;
        i_rst_n    = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        spur_fin   = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_values("por");
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Partial N load, then an asynchronous reset between clock edges.
        for (int i = 0; i < 10; i++) rx_byte(8'h80 | 8'($urandom));
        check(o_core_n != '0, "partial_n_loaded", o_core_n, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        load_key(256'h8F, 256'h07);
        load_block(256'h02, 1'b0);
        load_block(256'h03, 1'b1);
        for (int i = 0; i < 4; i++) load_block(256'($urandom_range(0, 142)), 1'b0);
        wait_idle();

        // Fresh key after a reset between blocks.
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_reset_values("rst2");
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        n2 = 256'(16'h8001 | 16'($urandom));
        d2 = 256'($urandom_range(1, 255));
        load_key(n2, d2);
        for (int i = 0; i < 2; i++) load_block(256'($urandom_range(0, int'(n2[15:0]) - 1)), 1'b0);
        wait_idle();

        check(starts_seen == blocks_issued, "start_count", starts_seen, blocks_issued);
        check(tx_popped == blocks_issued * OUT_BYTES, "tx_count", tx_popped, blocks_issued * OUT_BYTES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
